audio_fir_mac: RTL and testbench

AUDIO_FIR_MAC -- requirements
Module: audio_fir_mac

---
 rtl/audio_fir_mac.sv | 112 +++++++++++
 tb/tb_audio_fir_mac.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fir_mac.sv
// Sequential-MAC audio FIR filter: one multiply per cycle over a circular delay line.
// Define FIR_SATURATE_EN to clamp the output; otherwise the output wraps to 16 bits.
module audio_fir_mac #(
  parameter int TAPS = 8,
  parameter int CW   = 16,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [15:0]   out_data,
  input  logic          out_ready,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data
);

  localparam int PW = 16 + CW;
  localparam int ACCW = PW + AW;
  localparam logic [AW:0] MAC_LAST = (AW + 1)'(TAPS);
  localparam logic signed [CW-1:0] COEF_ONE = {1'b0, {(CW - 1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, next_state;

  logic signed [15:0]     delay_line [TAPS];
  logic signed [CW-1:0]   coef [TAPS];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            mac_cnt;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_sum;
  logic [15:0]            result;
  logic                   accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = MAC;
      MAC:     if (mac_cnt == MAC_LAST) next_state = OUT;
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The product is registered, so the last count only drains it into the sum.
  always_comb begin
    acc_sum = acc + {{AW{prod[PW-1]}}, prod};
`ifdef FIR_SATURATE_EN
    if (acc_sum[ACCW-1:30] != {(ACCW - 30){acc_sum[30]}})
      result = acc_sum[ACCW-1] ? 16'h8000 : 16'h7FFF;
    else
      result = acc_sum[30:15];
`else
    result = acc_sum[30:15];
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mac_cnt  <= '0;
      prod     <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int k = 0; k < TAPS; k++) begin
        delay_line[k] <= '0;
        coef[k]       <= (k == 0) ? COEF_ONE : '0;
      end
    end else begin
      state <= next_state;
      if (state == IDLE && coef_we)
        coef[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (accept) begin
            delay_line[wr_ptr] <= in_data;
            rd_ptr  <= wr_ptr;
            wr_ptr  <= wr_ptr + 1'b1;
            mac_cnt <= '0;
            prod    <= '0;
            acc     <= '0;
          end
        end
        MAC: begin
          acc     <= acc_sum;
          mac_cnt <= mac_cnt + 1'b1;
          // Walk backwards from the newest sample: x[n], x[n-1], ...
          if (mac_cnt != MAC_LAST) begin
            prod   <= coef[mac_cnt[AW-1:0]] * delay_line[rd_ptr];
            rd_ptr <= rd_ptr - 1'b1;
          end else begin
            out_data <= result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fir_mac.sv
// Directed testbench for audio_fir_mac with hand-computed expected outputs.
module tb_audio_fir_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;

  int pass_count = 0;
  int check_count = 0;

  audio_fir_mac #(.TAPS(8), .CW(16)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] k, input logic [15:0] v);
    coef_we   = 1'b1;
    coef_addr = k;
    coef_data = v;
    step();
    coef_we = 1'b0;
  endtask

  task automatic run_sample(input logic [15:0] d, output logic [15:0] y, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    y = out_data;
    if (out_ready) step();
  endtask

  task automatic test_reset();
    do_reset();
    check_count++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_count++;
    check_count++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_count++;
    check_count++;
    if (out_data !== 16'h0000) $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data);
    else pass_count++;
  endtask

  task automatic test_default_coef();
    logic [15:0] y;
    int lat;
    run_sample(16'h1234, y, lat);
    check_count++;
    if (y !== 16'h1233) $display("[TB] FAIL default_out: got %h expected 1233", y);
    else pass_count++;
    check_count++;
    if (lat !== 9) $display("[TB] FAIL default_latency: got %0d expected 9", lat);
    else pass_count++;
  endtask

  task automatic test_impulse();
    logic [15:0] y;
    logic [15:0] exp_y;
    int lat;
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(k * 16'h0100));
    for (int n = 0; n < 8; n++) begin
      run_sample((n == 0) ? 16'h4000 : 16'h0000, y, lat);
      exp_y = 16'(n * 16'h0080);
      check_count++;
      if (y !== exp_y) $display("[TB] FAIL impulse_out%0d: got %h expected %h", n, y, exp_y);
      else pass_count++;
    end
  endtask

  task automatic test_saturate();
    logic [15:0] y;
    logic [15:0] exp_last;
    int lat;
`ifdef FIR_SATURATE_EN
    exp_last = 16'h7FFF;
`else
    exp_last = 16'hFFF0;
`endif
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'h7FFF);
    for (int n = 0; n < 8; n++) begin
      run_sample(16'h7FFF, y, lat);
      if (n == 0) begin
        check_count++;
        if (y !== 16'h7FFE) $display("[TB] FAIL full_scale_first: got %h expected 7ffe", y);
        else pass_count++;
      end
    end
    check_count++;
    if (y !== exp_last) $display("[TB] FAIL full_scale_eighth: got %h expected %h", y, exp_last);
    else pass_count++;
  endtask

  task automatic test_hold();
    logic [15:0] y;
    int lat;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h5555;
      check_count++;
      if (out_valid !== 1'b1) $display("[TB] FAIL hold_valid%0d: got %b expected 1", i, out_valid);
      else pass_count++;
      check_count++;
      if (out_data !== 16'h1233) $display("[TB] FAIL hold_data%0d: got %h expected 1233", i, out_data);
      else pass_count++;
      check_count++;
      if (in_ready !== 1'b0) $display("[TB] FAIL hold_in_ready%0d: got %b expected 0", i, in_ready);
      else pass_count++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_count++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL hold_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else pass_count++;
    // With c[1]=0.5 and x[n]=0, output is x[n-1]/2, proving 0x5555 never landed
    write_coef(3'd1, 16'h4000);
    run_sample(16'h0000, y, lat);
    check_count++;
    if (y !== 16'h091A) $display("[TB] FAIL hold_ignored_in: got %h expected 091a", y);
    else pass_count++;
  endtask

  task automatic test_coef_during_mac();
    logic [15:0] y;
    int lat;
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    step();
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h0000;
    step();
    step();
    step();
    coef_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check_count++;
    if (out_data !== 16'h1233) $display("[TB] FAIL mac_write_cur: got %h expected 1233", out_data);
    else pass_count++;
    step();
    run_sample(16'h1234, y, lat);
    check_count++;
    if (y !== 16'h1233) $display("[TB] FAIL mac_write_next: got %h expected 1233", y);
    else pass_count++;
  endtask

  task automatic test_reset_mid_mac();
    logic [15:0] y;
    int lat;
    int seen;
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_count++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL abort_state: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else pass_count++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      step();
    end
    check_count++;
    if (seen !== 0) $display("[TB] FAIL abort_no_output: got %0d valid cycles expected 0", seen);
    else pass_count++;
    run_sample(16'h1234, y, lat);
    check_count++;
    if (y !== 16'h1233) $display("[TB] FAIL abort_next_out: got %h expected 1233", y);
    else pass_count++;
    check_count++;
    if (lat !== 9) $display("[TB] FAIL abort_next_latency: got %0d expected 9", lat);
    else pass_count++;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    #1;
    test_reset();
    test_default_coef();
    test_impulse();
    test_saturate();
    test_hold();
    test_coef_during_mac();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
